// File: rtl/rect_scan_gen.sv
// Rectangle pixel-coordinate generator: latches a draw command, clips it to the
// screen, then streams raster-order coordinates (filled or outline) over valid/ready.
module rect_scan_gen #(
   parameter int COORD_W  = 11,
   parameter int DIM_W    = 7,
   parameter int COLOR_W  = 12,
   parameter int SCREEN_W = 640,
   parameter int SCREEN_H = 480
) (
   input  logic               clock,
   input  logic               reset,
   input  logic               start,
   input  logic [COORD_W-1:0] x_origin,
   input  logic [COORD_W-1:0] y_origin,
   input  logic [DIM_W-1:0]   width,
   input  logic [DIM_W-1:0]   height,
   input  logic [COLOR_W-1:0] color,
   input  logic               outline,
   input  logic               out_ready,
   output logic               out_valid,
   output logic [COORD_W-1:0] x_coord,
   output logic [COORD_W-1:0] y_coord,
   output logic [COLOR_W-1:0] pix_color,
   output logic               pix_last,
   output logic               busy,
   output logic               done
);

   localparam int EW = COORD_W + 1;
   localparam logic [EW-1:0] SCR_W = EW'(SCREEN_W);
   localparam logic [EW-1:0] SCR_H = EW'(SCREEN_H);

   typedef enum logic [1:0] {IDLE, SETUP, SCAN, FINISH} state_t;

   state_t             state_q, state_d;
   logic               busy_q, busy_d;
   logic               done_q, done_d;
   logic               valid_q, valid_d;
   logic               last_q, last_d;
   logic [COORD_W-1:0] x_q, x_d;
   logic [COORD_W-1:0] y_q, y_d;
   logic [COLOR_W-1:0] color_q, color_d;

   logic [COORD_W-1:0] x0_q, x0_d;
   logic [COORD_W-1:0] y0_q, y0_d;
   logic [DIM_W-1:0]   w_q, w_d;
   logic [DIM_W-1:0]   h_q, h_d;
   logic               outline_q, outline_d;
   logic [EW-1:0]      xe_q, xe_d;
   logic [EW-1:0]      ye_q, ye_d;

   logic [EW-1:0]      sum_x, sum_y, xe_calc, ye_calc, xl, yl, x_ext, y_ext;
   logic               empty, first_last, next_last, mid_row;
   logic [COORD_W-1:0] nx, ny;

   // Extent clipping and next-pixel arithmetic, all unsigned in COORD_W+1 bits
   always_comb begin
      sum_x      = EW'(x0_q) + EW'(w_q);
      sum_y      = EW'(y0_q) + EW'(h_q);
      xe_calc    = (sum_x > SCR_W) ? SCR_W : sum_x;
      ye_calc    = (sum_y > SCR_H) ? SCR_H : sum_y;
      empty      = (w_q == '0) || (h_q == '0) ||
                   (EW'(x0_q) >= SCR_W) || (EW'(y0_q) >= SCR_H);
      xl         = xe_q - 1'b1;
      yl         = ye_q - 1'b1;
      x_ext      = EW'(x_q);
      y_ext      = EW'(y_q);
      mid_row    = outline_q && (y_ext > EW'(y0_q)) && (y_ext < yl);
      nx         = x_q;
      ny         = y_q;
      if (x_ext < xl) begin
         if (mid_row && (x_q == x0_q))
            nx = xl[COORD_W-1:0];
         else
            nx = x_q + 1'b1;
      end else begin
         nx = x0_q;
         ny = y_q + 1'b1;
      end
      next_last  = (EW'(nx) == xl) && (EW'(ny) == yl);
      first_last = (EW'(x0_q) == xl) && (EW'(y0_q) == yl);
   end

   always_comb begin
      state_d   = state_q;
      busy_d    = busy_q;
      done_d    = 1'b0;
      valid_d   = valid_q;
      last_d    = last_q;
      x_d       = x_q;
      y_d       = y_q;
      color_d   = color_q;
      x0_d      = x0_q;
      y0_d      = y0_q;
      w_d       = w_q;
      h_d       = h_q;
      outline_d = outline_q;
      xe_d      = xe_q;
      ye_d      = ye_q;
      case (state_q)
         IDLE: begin
            if (start) begin
               x0_d      = x_origin;
               y0_d      = y_origin;
               w_d       = width;
               h_d       = height;
               outline_d = outline;
               color_d   = color;
               busy_d    = 1'b1;
               state_d   = SETUP;
            end
         end
         SETUP: begin
            xe_d    = xe_calc;
            ye_d    = ye_calc;
            state_d = empty ? FINISH : SCAN;
         end
         SCAN: begin
            // First SCAN cycle presents the origin; afterwards advance on handshake
            if (!valid_q) begin
               valid_d = 1'b1;
               x_d     = x0_q;
               y_d     = y0_q;
               last_d  = first_last;
            end else if (out_ready) begin
               if (last_q) begin
                  valid_d = 1'b0;
                  last_d  = 1'b0;
                  state_d = FINISH;
               end else begin
                  x_d    = nx;
                  y_d    = ny;
                  last_d = next_last;
               end
            end
         end
         FINISH: begin
            done_d  = 1'b1;
            busy_d  = 1'b0;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clock) begin
      if (!reset) begin
         state_q <= IDLE;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         valid_q <= 1'b0;
         last_q  <= 1'b0;
         x_q     <= '0;
         y_q     <= '0;
         color_q <= '0;
      end else begin
         state_q <= state_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         valid_q <= valid_d;
         last_q  <= last_d;
         x_q     <= x_d;
         y_q     <= y_d;
         color_q <= color_d;
      end
   end

   // Command geometry is only consumed after a fresh latch, so it needs no reset
   always_ff @(posedge clock) begin
      x0_q      <= x0_d;
      y0_q      <= y0_d;
      w_q       <= w_d;
      h_q       <= h_d;
      outline_q <= outline_d;
      xe_q      <= xe_d;
      ye_q      <= ye_d;
   end

   assign out_valid = valid_q;
   assign x_coord   = x_q;
   assign y_coord   = y_q;
   assign pix_color = color_q;
   assign pix_last  = last_q;
   assign busy      = busy_q;
   assign done      = done_q;

endmodule

// File: tb/tb_rect_scan_gen.sv
// Directed bench for rect_scan_gen: command table with hand-written pixel lists,
// plus hand sequences for backpressure, mid-command reset and ignored start.
module tb_rect_scan_gen;

   localparam int CW = 11;
   localparam int DW = 7;
   localparam int KW = 12;

   logic          clock = 1'b0;
   logic          reset = 1'b0;
   logic          start = 1'b0;
   logic [CW-1:0] x_origin = '0;
   logic [CW-1:0] y_origin = '0;
   logic [DW-1:0] width = '0;
   logic [DW-1:0] height = '0;
   logic [KW-1:0] color = '0;
   logic          outline = 1'b0;
   logic          out_ready = 1'b0;
   logic          out_valid;
   logic [CW-1:0] x_coord;
   logic [CW-1:0] y_coord;
   logic [KW-1:0] pix_color;
   logic          pix_last;
   logic          busy;
   logic          done;

   rect_scan_gen dut (
      .clock(clock), .reset(reset), .start(start),
      .x_origin(x_origin), .y_origin(y_origin), .width(width), .height(height),
      .color(color), .outline(outline), .out_ready(out_ready),
      .out_valid(out_valid), .x_coord(x_coord), .y_coord(y_coord),
      .pix_color(pix_color), .pix_last(pix_last), .busy(busy), .done(done)
   );

   always #5 clock = ~clock;

   typedef struct {
      int x;
      int y;
   } pix_t;

   typedef struct {
      int x0;
      int y0;
      int w;
      int h;
      bit ol;
      int col;
      int first;
      int n;
      int done_c;
      int busy_c;
   } cmd_t;

   pix_t px[$];
   cmd_t cmds[$];
   int   errors = 0;
   int   checks = 0;

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic add_px(input int x, input int y);
      pix_t p;
      p.x = x;
      p.y = y;
      px.push_back(p);
   endtask

   task automatic add_cmd(input int x0, input int y0, input int w, input int h,
                          input bit ol, input int col, input int n,
                          input int done_c, input int busy_c);
      cmd_t c;
      c.x0 = x0; c.y0 = y0; c.w = w; c.h = h; c.ol = ol; c.col = col;
      c.n = n; c.done_c = done_c; c.busy_c = busy_c;
      c.first = px.size() - n;
      cmds.push_back(c);
   endtask

   // Cycle c means "the cycle after edge N+c-1" where edge N accepts start.
   task automatic run_cmd(input int ci, input bit stall, input bit poke);
      cmd_t c;
      int   k, first_c, done_c, busy_c, stray;
      bit   pv, pr;
      int   pxv, pyv;
      c = cmds[ci];
      k = 0; first_c = -1; done_c = -1; busy_c = 0; pv = 0; pr = 0; pxv = 0; pyv = 0;
      @(negedge clock);
      x_origin = CW'(c.x0); y_origin = CW'(c.y0);
      width = DW'(c.w); height = DW'(c.h);
      outline = c.ol; color = KW'(c.col); start = 1'b1;
      for (int cy = 1; cy <= 300; cy++) begin
         @(negedge clock);
         if (cy == 1) start = 1'b0;
         if (poke && cy == 5) begin
            x_origin = 11'd300; y_origin = 11'd300; width = 7'd2; height = 7'd2;
            outline = 1'b1; color = 12'h777; start = 1'b1;
         end
         if (poke && cy == 6) start = 1'b0;
         out_ready = stall ? ((cy % 3) == 0) : 1'b1;
         if (busy) busy_c++;
         if (pv && !pr) begin
            check($sformatf("hold_valid cmd%0d", ci), int'(out_valid), 1);
            check($sformatf("hold_x cmd%0d", ci), int'(x_coord), pxv);
            check($sformatf("hold_y cmd%0d", ci), int'(y_coord), pyv);
         end
         if (out_valid && first_c < 0) first_c = cy;
         if (out_valid && out_ready) begin
            if (k < c.n) begin
               check($sformatf("x cmd%0d pix%0d", ci, k), int'(x_coord), px[c.first + k].x);
               check($sformatf("y cmd%0d pix%0d", ci, k), int'(y_coord), px[c.first + k].y);
               check($sformatf("last cmd%0d pix%0d", ci, k), int'(pix_last), int'(k == c.n - 1));
               check($sformatf("color cmd%0d pix%0d", ci, k), int'(pix_color), c.col);
            end
            k++;
         end
         pv = out_valid; pr = out_ready; pxv = int'(x_coord); pyv = int'(y_coord);
         if (done) begin
            done_c = cy;
            break;
         end
      end
      check($sformatf("pixel_count cmd%0d", ci), k, c.n);
      check($sformatf("done_seen cmd%0d", ci), int'(done_c > 0), 1);
      check($sformatf("valid_at_done cmd%0d", ci), int'(out_valid), 0);
      if (!stall) begin
         check($sformatf("done_cycle cmd%0d", ci), done_c, c.done_c);
         check($sformatf("busy_cycles cmd%0d", ci), busy_c, c.busy_c);
         check($sformatf("first_valid cmd%0d", ci), first_c, (c.n > 0) ? 3 : -1);
      end
      if (poke) begin
         stray = 0;
         for (int cy = 0; cy < 20; cy++) begin
            @(negedge clock);
            if (out_valid || busy || done) stray++;
         end
         check("second_cmd_ran", stray, 0);
      end
      out_ready = 1'b0;
   endtask

   initial begin
      int hs;
      // Table: filled 3x2 at (10,20)
      add_px(10,20); add_px(11,20); add_px(12,20);
      add_px(10,21); add_px(11,21); add_px(12,21);
      add_cmd(10, 20, 3, 2, 1'b0, 'hABC, 6, 10, 9);
      // Outline 4x4 at (0,0)
      add_px(0,0); add_px(1,0); add_px(2,0); add_px(3,0);
      add_px(0,1); add_px(3,1); add_px(0,2); add_px(3,2);
      add_px(0,3); add_px(1,3); add_px(2,3); add_px(3,3);
      add_cmd(0, 0, 4, 4, 1'b1, 'h123, 12, 16, 15);
      // Filled 5x3 at (638,478), clipped to 2x2
      add_px(638,478); add_px(639,478); add_px(638,479); add_px(639,479);
      add_cmd(638, 478, 5, 3, 1'b0, 'hF0F, 4, 8, 7);
      // Origin off-screen: empty
      add_cmd(700, 10, 5, 3, 1'b0, 'h001, 0, 3, 2);
      // Outline clipped to one column at the right edge
      add_px(639,0); add_px(639,1); add_px(639,2);
      add_cmd(639, 0, 3, 3, 1'b1, 'h0F0, 3, 7, 6);
      // Zero width: empty
      add_cmd(5, 5, 0, 4, 1'b0, 'h002, 0, 3, 2);
      // Outline 3x5 at (20,30)
      add_px(20,30); add_px(21,30); add_px(22,30);
      add_px(20,31); add_px(22,31); add_px(20,32); add_px(22,32);
      add_px(20,33); add_px(22,33);
      add_px(20,34); add_px(21,34); add_px(22,34);
      add_cmd(20, 30, 3, 5, 1'b1, 'h456, 12, 16, 15);

      repeat (3) @(negedge clock);
      check("rst_valid", int'(out_valid), 0);
      check("rst_busy", int'(busy), 0);
      check("rst_done", int'(done), 0);
      check("rst_last", int'(pix_last), 0);
      check("rst_x", int'(x_coord), 0);
      check("rst_y", int'(y_coord), 0);
      check("rst_color", int'(pix_color), 0);
      reset = 1'b1;
      @(negedge clock);

      for (int i = 0; i < cmds.size(); i++) run_cmd(i, 1'b0, 1'b0);

      // Backpressure on the 3x2 fill
      run_cmd(0, 1'b1, 1'b0);

      // Mid-command reset during a 4x4 fill
      @(negedge clock);
      x_origin = 11'd100; y_origin = 11'd100; width = 7'd4; height = 7'd4;
      outline = 1'b0; color = 12'h555; start = 1'b1; out_ready = 1'b1;
      hs = 0;
      for (int cy = 0; cy < 50; cy++) begin
         @(negedge clock);
         start = 1'b0;
         if (out_valid) begin
            hs++;
            if (hs == 2) break;
         end
      end
      check("reset_test_reached_2nd", hs, 2);
      @(negedge clock);
      check("pre_reset_x", int'(x_coord), 102);
      reset = 1'b0;
      @(negedge clock);
      check("midrst_valid", int'(out_valid), 0);
      check("midrst_busy", int'(busy), 0);
      check("midrst_done", int'(done), 0);
      reset = 1'b1;
      out_ready = 1'b0;
      repeat (2) @(negedge clock);
      check("post_rst_idle_done", int'(done), 0);
      run_cmd(0, 1'b0, 1'b0);

      // Start pulsed while busy is ignored
      run_cmd(0, 1'b0, 1'b1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
